// File: rtl/topk_classifier.sv
// Top-K classifier: consumes a serial stream of unsigned Q0.8 class
// probabilities (class index = arrival order), keeps the TOP_K best entries
// in a sorted register array via single-cycle parallel insertion, then
// streams the ranked results out over valid/ready and pulses done.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, num_classes   begin a run (sampled in IDLE), class count captured
//   valid_in, data_in    probability beats (no backpressure)
//   out_valid/out_ready  result handshake; out_rank/out_index/out_prob payload
//   busy                 high whenever not IDLE
//   done                 one-cycle pulse after the final result handshake
module topk_classifier #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 10,
    parameter int unsigned TOP_K      = 5,
    localparam int unsigned RANK_WIDTH = $clog2(TOP_K) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IDX_WIDTH-1:0]  num_classes,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RANK_WIDTH-1:0] out_rank,
    output logic [IDX_WIDTH-1:0]  out_index,
    output logic [DATA_WIDTH-1:0] out_prob,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] EMIT    = 2'd2;
    localparam logic [1:0] FINISH  = 2'd3;

    localparam logic [IDX_WIDTH-1:0]  ONE_IDX  = 1;
    localparam logic [RANK_WIDTH-1:0] ONE_RANK = 1;

    logic [1:0]            state_q;
    logic [IDX_WIDTH-1:0]  num_q;
    logic [IDX_WIDTH-1:0]  cnt_q;

    logic [DATA_WIDTH-1:0] slot_prob_q [TOP_K];
    logic [IDX_WIDTH-1:0]  slot_idx_q  [TOP_K];
    logic [TOP_K-1:0]      slot_vld_q;

    logic [DATA_WIDTH-1:0] slot_prob_d [TOP_K];
    logic [IDX_WIDTH-1:0]  slot_idx_d  [TOP_K];
    logic [TOP_K-1:0]      slot_vld_d;

    // ge[i]: slot i stays ahead of the incoming beat. Slots are sorted with
    // valid entries first, so ge is a contiguous run of ones from slot 0.
    logic [TOP_K-1:0] ge;
    logic [TOP_K:0]   ge_ext;

    always_comb begin
        for (int i = 0; i < TOP_K; i++) begin
            ge[i] = slot_vld_q[i] && (slot_prob_q[i] >= data_in);
        end
        ge_ext = {ge, 1'b1};
    end

    // Slot at the ge boundary takes the new beat, slots below it shift down.
    always_comb begin
        slot_prob_d = slot_prob_q;
        slot_idx_d  = slot_idx_q;
        slot_vld_d  = slot_vld_q;
        for (int i = 0; i < TOP_K; i++) begin
            if (ge_ext[i] && !ge[i]) begin
                slot_prob_d[i] = data_in;
                slot_idx_d[i]  = cnt_q;
                slot_vld_d[i]  = 1'b1;
            end
        end
        for (int i = 1; i < TOP_K; i++) begin
            if (!ge_ext[i]) begin
                slot_prob_d[i] = slot_prob_q[i-1];
                slot_idx_d[i]  = slot_idx_q[i-1];
                slot_vld_d[i]  = slot_vld_q[i-1];
            end
        end
    end

    // Rank of the final emitted entry: min(TOP_K, num_classes) - 1.
    logic [RANK_WIDTH-1:0] last_rank;
    logic [RANK_WIDTH-1:0] next_rank;
    logic [DATA_WIDTH-1:0] next_prob;
    logic [IDX_WIDTH-1:0]  next_idx;

    always_comb begin
        if (num_q >= IDX_WIDTH'(TOP_K)) begin
            last_rank = RANK_WIDTH'(TOP_K - 1);
        end else begin
            last_rank = RANK_WIDTH'(num_q - ONE_IDX);
        end
        next_rank = out_rank + ONE_RANK;
        next_prob = '0;
        next_idx  = '0;
        for (int i = 0; i < TOP_K; i++) begin
            if (RANK_WIDTH'(i) == next_rank) begin
                next_prob = slot_prob_q[i];
                next_idx  = slot_idx_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            num_q      <= '0;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            out_rank   <= '0;
            out_index  <= '0;
            out_prob   <= '0;
            done       <= 1'b0;
            slot_vld_q <= '0;
            for (int i = 0; i < TOP_K; i++) begin
                slot_prob_q[i] <= '0;
                slot_idx_q[i]  <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        num_q      <= num_classes;
                        cnt_q      <= '0;
                        slot_vld_q <= '0;
                        if (num_classes == '0) begin
                            state_q <= FINISH;
                            done    <= 1'b1;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (valid_in) begin
                        slot_prob_q <= slot_prob_d;
                        slot_idx_q  <= slot_idx_d;
                        slot_vld_q  <= slot_vld_d;
                        cnt_q       <= cnt_q + ONE_IDX;
                        if (cnt_q == num_q - ONE_IDX) begin
                            state_q <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (!out_valid) begin
                        // First EMIT cycle: present rank 0.
                        out_valid <= 1'b1;
                        out_rank  <= '0;
                        out_index <= slot_idx_q[0];
                        out_prob  <= slot_prob_q[0];
                    end else if (out_ready) begin
                        if (out_rank == last_rank) begin
                            out_valid <= 1'b0;
                            state_q   <= FINISH;
                            done      <= 1'b1;
                        end else begin
                            out_rank  <= next_rank;
                            out_index <= next_idx;
                            out_prob  <= next_prob;
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);

endmodule
